// File: rtl/gpio_peripheral.sv
// ============================================================================
// Module   : gpio_peripheral
// Brief    : Memory-mapped GPIO: LED register, synchronised/debounced switches,
//            sticky change flags and level interrupt. Macro: GPIO_DEBOUNCE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gpio_peripheral #(
    parameter int N_IO            = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sel,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic [N_IO-1:0] switches,
    output logic [N_IO-1:0] leds,
    output logic            irq
);

    localparam logic [1:0] c_addr_sw   = 2'd0;
    localparam logic [1:0] c_addr_led  = 2'd1;
    localparam logic [1:0] c_addr_edge = 2'd2;
    localparam logic [1:0] c_addr_ctrl = 2'd3;

    logic [N_IO-1:0] s1_q, s1_d;
    logic [N_IO-1:0] s2_q, s2_d;
    logic [N_IO-1:0] sw_stable_q, sw_stable_d;
    logic [N_IO-1:0] led_q, led_d;
    logic [N_IO-1:0] edge_q, edge_d;
    logic            irq_en_q, irq_en_d;

    logic w_wr;
    logic w_unused_wdata;

    assign w_wr           = sel & we;
    assign w_unused_wdata = ^wdata;

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_IO-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // One shared counter: any bit moving away from cand restarts the window.
    always_comb begin
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        sw_stable_d = sw_stable_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cand_q != sw_stable_q) begin
            if (cnt_q == c_cnt_last) begin
                sw_stable_d = cand_q;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    localparam int c_unused_cfg = DEBOUNCE_CYCLES + CNT_W;

    always_comb begin
        sw_stable_d = s2_q;
    end
`endif

    always_comb begin
        s1_d     = switches;
        s2_d     = s1_q;
        led_d    = led_q;
        irq_en_d = irq_en_q;
        edge_d   = edge_q;
        if (w_wr && addr == c_addr_led) begin
            led_d = wdata[N_IO-1:0];
        end
        if (w_wr && addr == c_addr_ctrl) begin
            irq_en_d = wdata[0];
        end
        if (w_wr && addr == c_addr_edge) begin
            edge_d = edge_q & ~wdata[N_IO-1:0];
        end
        // Applied after the clear so a same-edge change keeps its flag.
        edge_d = edge_d | (sw_stable_d ^ sw_stable_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            sw_stable_q <= '0;
            led_q       <= '0;
            edge_q      <= '0;
            irq_en_q    <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            sw_stable_q <= sw_stable_d;
            led_q       <= led_d;
            edge_q      <= edge_d;
            irq_en_q    <= irq_en_d;
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (sel) begin
            case (addr)
                c_addr_sw:   rdata = 32'(sw_stable_q);
                c_addr_led:  rdata = 32'(led_q);
                c_addr_edge: rdata = 32'(edge_q);
                default:     rdata = {31'h0, irq_en_q};
            endcase
        end
    end

    assign leds = led_q;
    assign irq  = irq_en_q & (|edge_q);

endmodule

`default_nettype wire
